div_seq: RTL and testbench

DIV_SEQ -- requirements
Module: div_seq

---
 rtl/div_pkg.sv | 13 +
 rtl/addsub_n.sv | 30 +++
 rtl/div_seq.sv | 164 ++++++++++++++++
 tb/tb_div_seq.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared FSM encoding and default width for the sequential divider.
package div_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/addsub_n.sv
// N-bit ripple-carry adder/subtractor; sub=1 computes a - b as a + ~b + 1.
module addsub_n #(
    parameter int N = 33
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] sum,
    output logic         carry_out,
    output logic         overflow
);

    logic [N:0]   carry;
    logic [N-1:0] b_eff;

    always_comb begin
        carry    = '0;
        sum      = '0;
        b_eff    = b ^ {N{sub}};
        carry[0] = sub;
        for (int i = 0; i < N; i++) begin
            sum[i]     = a[i] ^ b_eff[i] ^ carry[i];
            carry[i+1] = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
        end
    end

    assign carry_out = carry[N];
    assign overflow  = carry[N] ^ carry[N-1];

endmodule

// File: rtl/div_seq.sv
// Sequential restoring divider, one quotient bit per cycle, signed or unsigned.
// Divide-by-zero and signed MIN/-1 bypass the iteration and finish in two cycles.
module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]    LAST_IT = CW'(WIDTH - 1);

    div_state_t       state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic             rsgn_q, rsgn_d;
    logic             byp_q, byp_d;
    logic             dz_q, dz_d;
    logic             ov_q, ov_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic             dvd_neg, dvs_neg;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic [WIDTH:0]   rem_sh, trial_b, trial_diff;
    logic             trial_ok, trial_ovf_unused, trial_msb_unused;

    // Partial remainder always stays below the divisor, so WIDTH+1 bits
    // is enough for the shifted value and the trial difference.
    assign rem_sh           = {rem_q, quo_q[WIDTH-1]};
    assign trial_b          = {1'b0, dvs_q};
    assign trial_msb_unused = trial_diff[WIDTH];

    addsub_n #(.N(WIDTH + 1)) u_trial (
        .a         (rem_sh),
        .b         (trial_b),
        .sub       (1'b1),
        .sum       (trial_diff),
        .carry_out (trial_ok),
        .overflow  (trial_ovf_unused)
    );

    always_comb begin
        dvd_neg = is_signed & dividend[WIDTH-1];
        dvs_neg = is_signed & divisor[WIDTH-1];
        dvd_mag = dvd_neg ? -dividend : dividend;
        dvs_mag = dvs_neg ? -divisor  : divisor;

        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        rsgn_d  = rsgn_q;
        byp_d   = byp_q;
        dz_d    = dz_q;
        ov_d    = ov_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = FIX;
                    byp_d   = 1'b1;
                    dz_d    = 1'b0;
                    ov_d    = 1'b0;
                    cnt_d   = '0;
                    if (divisor == '0) begin
                        quo_d = '1;
                        rem_d = dividend;
                        dz_d  = 1'b1;
                    end else if (is_signed && dividend == MIN_VAL && divisor == '1) begin
                        quo_d = MIN_VAL;
                        rem_d = '0;
                        ov_d  = 1'b1;
                    end else begin
                        state_d = CALC;
                        byp_d   = 1'b0;
                        quo_d   = dvd_mag;
                        rem_d   = '0;
                        dvs_d   = dvs_mag;
                        neg_d   = dvd_neg ^ dvs_neg;
                        rsgn_d  = dvd_neg;
                    end
                end
            end
            CALC: begin
                rem_d = trial_ok ? trial_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], trial_ok};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_IT) state_d = FIX;
            end
            FIX: begin
                if (!byp_q) begin
                    if (neg_q)  quo_d = -quo_q;
                    if (rsgn_q) rem_d = -rem_q;
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            rsgn_q      <= 1'b0;
            byp_q       <= 1'b0;
            dz_q        <= 1'b0;
            ov_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            rsgn_q      <= rsgn_d;
            byp_q       <= byp_d;
            dz_q        <= dz_d;
            ov_q        <= ov_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dz_q;
    assign overflow    = ov_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed vector bench for div_seq at WIDTH=32, plus backpressure and reset sequences.
module tb_div_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, is_signed;
    logic         out_valid, out_ready, div_by_zero, overflow;
    logic [W-1:0] dividend, divisor, quotient, remainder;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int acc_cyc;
    int lat;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    div_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .is_signed   (is_signed),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    typedef struct {
        logic [31:0] dvd;
        logic [31:0] dvs;
        logic        sgn;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        ov;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
        int t;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL in_ready_timeout: got 0 want 1");
        end
        dividend  = a;
        divisor   = b;
        is_signed = s;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        acc_cyc  = cyc;
    endtask

    task automatic wait_done(output int l);
        @(negedge clk);
        while (!out_valid && (cyc - acc_cyc) < 200) @(negedge clk);
        if (!out_valid) begin
            n_cmp++;
            n_err++;
            $display("FAIL out_valid_timeout: got 0 want 1");
        end
        l = cyc - acc_cyc;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{32'd100,      32'd7,        1'b0, 32'd14,       32'd2,        1'b0, 1'b0, 33};
        vecs[1]  = '{32'hFFFFFFF9, 32'h00000002, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 33};
        vecs[2]  = '{32'hFFFFFFF9, 32'h00000002, 1'b0, 32'h7FFFFFFC, 32'h00000001, 1'b0, 1'b0, 33};
        vecs[3]  = '{32'd5,        32'd0,        1'b0, 32'hFFFFFFFF, 32'd5,        1'b1, 1'b0, 1};
        vecs[4]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'h00000000, 1'b0, 1'b1, 1};
        vecs[5]  = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h80000000, 1'b0, 1'b0, 33};
        vecs[6]  = '{32'h00000007, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'h00000001, 1'b0, 1'b0, 33};
        vecs[7]  = '{32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, 32'h00000003, 32'hFFFFFFFF, 1'b0, 1'b0, 33};
        vecs[8]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 33};
        vecs[9]  = '{32'hFFFFFFF9, 32'h00000000, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1, 1'b0, 1};
        vecs[10] = '{32'h80000000, 32'h00000002, 1'b1, 32'hC0000000, 32'h00000000, 1'b0, 1'b0, 33};
        vecs[11] = '{32'd3,        32'd5,        1'b0, 32'd0,        32'd3,        1'b0, 1'b0, 33};
        vecs[12] = '{32'h12345678, 32'd1000,     1'b0, 32'h0004A90B, 32'h00000380, 1'b0, 1'b0, 33};
        vecs[13] = '{32'hFFFFFF9C, 32'd7,        1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 1'b0, 33};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst.in_ready",  32'(in_ready),    32'd1);
        chk("rst.out_valid", 32'(out_valid),   32'd0);
        chk("rst.q",         quotient,         32'd0);
        chk("rst.r",         remainder,        32'd0);
        chk("rst.dz",        32'(div_by_zero), 32'd0);
        chk("rst.ov",        32'(overflow),    32'd0);

        for (int i = 0; i < 14; i++) begin
            start_op(vecs[i].dvd, vecs[i].dvs, vecs[i].sgn);
            wait_done(lat);
            chk($sformatf("v%0d.q", i),   quotient,          vecs[i].q);
            chk($sformatf("v%0d.r", i),   remainder,         vecs[i].r);
            chk($sformatf("v%0d.dz", i),  32'(div_by_zero),  32'(vecs[i].dz));
            chk($sformatf("v%0d.ov", i),  32'(overflow),     32'(vecs[i].ov));
            chk($sformatf("v%0d.lat", i), 32'(lat),          32'(vecs[i].lat));
            consume();
        end

        // Stray in_valid pulses mid-CALC, then 5 cycles of backpressure in DONE.
        start_op(32'd100, 32'd7, 1'b0);
        dividend = 32'd999;
        divisor  = 32'd3;
        repeat (3) begin
            @(negedge clk);
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
        end
        wait_done(lat);
        chk("hold.lat", 32'(lat), 32'd33);
        repeat (5) begin
            @(negedge clk);
            chk("hold.q",         quotient,         32'd14);
            chk("hold.r",         remainder,        32'd2);
            chk("hold.out_valid", 32'(out_valid),   32'd1);
            chk("hold.in_ready",  32'(in_ready),    32'd0);
            chk("hold.dz",        32'(div_by_zero), 32'd0);
        end
        consume();
        @(negedge clk);
        chk("bubble.in_ready",  32'(in_ready),  32'd1);
        chk("bubble.out_valid", 32'(out_valid), 32'd0);
        chk("idle_hold.q",      quotient,       32'd14);

        // Reset after 10 CALC iterations discards the operation.
        start_op(32'd100, 32'd7, 1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst.q",         quotient,         32'd0);
        chk("midrst.r",         remainder,        32'd0);
        chk("midrst.in_ready",  32'(in_ready),    32'd1);
        chk("midrst.out_valid", 32'(out_valid),   32'd0);
        chk("midrst.dz",        32'(div_by_zero), 32'd0);
        chk("midrst.ov",        32'(overflow),    32'd0);
        repeat (40) @(negedge clk);
        chk("midrst.no_result", 32'(out_valid),   32'd0);

        start_op(32'hFFFFFFFF, 32'd1, 1'b0);
        wait_done(lat);
        chk("post.q",   quotient,  32'hFFFFFFFF);
        chk("post.r",   remainder, 32'd0);
        chk("post.lat", 32'(lat),  32'd33);
        consume();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
